// File: rtl/mod_reduce65_pipe.sv
// Two-stage conditional-subtract reduction of a 65-bit adder sum modulo the NTT prime.
// Valid/ready pipeline with sideband tag and a sticky carry-out overflow flag.
module mod_reduce65_pipe #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MODULUS    = 64'hFFFFFFFF00000001,
  parameter int unsigned           TAG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   in_sum,
  input  logic                  in_carry,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  ovf_err,
  input  logic                  clr_err
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;
  localparam logic [SUM_W-1:0] MOD_EXT = {1'b0, MODULUS};
  localparam logic [SUM_W-1:0] TWO_P   = {MODULUS, 1'b0};

  logic                  v1;
  logic [SUM_W-1:0]      r1;
  logic [TAG_W-1:0]      tag1;
  logic                  v2;
  logic [DATA_WIDTH-1:0] r2;
  logic [TAG_W-1:0]      tag2;

  logic                  en1;
  logic                  en2;
  logic                  take;
  logic [SUM_W-1:0]      r1_nxt;
  logic [DATA_WIDTH-1:0] r2_nxt;

  // Stage enables, handshake and the two conditional subtracts
  always_comb begin
    en2      = !v2 || out_ready;
    en1      = !v1 || en2;
    in_ready = en1 || rst;
    take     = in_valid && en1 && !rst;
    r1_nxt   = (in_sum >= TWO_P) ? SUM_W'(in_sum - TWO_P) : in_sum;
    r2_nxt   = (r1 >= MOD_EXT) ? DATA_WIDTH'(r1 - MOD_EXT) : DATA_WIDTH'(r1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      r1   <= '0;
      tag1 <= '0;
      v2   <= 1'b0;
      r2   <= '0;
      tag2 <= '0;
    end else begin
      if (en1) begin
        v1   <= take;
        r1   <= r1_nxt;
        tag1 <= in_tag;
      end
      if (en2) begin
        v2   <= v1;
        r2   <= r2_nxt;
        tag2 <= tag1;
      end
    end
  end

  // Sticky overflow: a new carry beat takes priority over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (take && in_carry) begin
      ovf_err <= 1'b1;
    end else if (clr_err) begin
      ovf_err <= 1'b0;
    end
  end

  assign out_valid = v2;
  assign out_data  = r2;
  assign out_tag   = tag2;

endmodule

// File: tb/tb_mod_reduce65_pipe.sv
// Directed and randomised checks of mod_reduce65_pipe against an independent modulo model.
module tb_mod_reduce65_pipe;

  localparam logic [63:0] P     = 64'hFFFFFFFF00000001;
  localparam logic [64:0] P_EXT = {1'b0, P};

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] in_sum;
  logic        in_carry;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_tag;
  logic        ovf_err;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  mod_reduce65_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .ovf_err   (ovf_err),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_sum = 65'd42; in_tag = 8'hEE;
    in_carry = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    step; step;
    rst = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++;
    if (out_tag !== 8'd0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err got=%b exp=0", ovf_err); end
    out_ready = 1'b1;
    step; step;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture got=%b exp=0", out_valid); end
  endtask

  task automatic test_single;
    logic [64:0] xs [5];
    logic [63:0] ex [5];
    xs[0] = 65'd5;                      ex[0] = 64'd5;
    xs[1] = 65'h0_FFFFFFFF_00000001;    ex[1] = 64'd0;
    xs[2] = 65'h1_FFFFFFFE_00000001;    ex[2] = 64'hFFFFFFFF00000000;
    xs[3] = 65'h1_FFFFFFFE_00000002;    ex[3] = 64'd0;
    xs[4] = 65'h1_FFFFFFFF_FFFFFFFF;    ex[4] = 64'h1_FFFFFFFD;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sum = xs[i]; in_tag = 8'(8'h10 + i);
      step;
      in_valid = 1'b0;
      step;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL single%0d_valid got=%b exp=1", i, out_valid); end
      checks++;
      if (out_data !== ex[i]) begin errors++; $display("FAIL single%0d_data got=%h exp=%h", i, out_data, ex[i]); end
      checks++;
      if (out_tag !== 8'(8'h10 + i)) begin errors++; $display("FAIL single%0d_tag got=%h exp=%h", i, out_tag, 8'(8'h10 + i)); end
      step;
    end
  endtask

  // Streams n beats; rnd enables random in_valid/out_ready, otherwise full rate
  task automatic run_stream(input int n, input bit rnd, input int budget, input string name);
    logic [63:0] exp_d [$];
    logic [7:0]  exp_t [$];
    logic [64:0] x;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((sent < n || got < sent) && cyc < budget) begin
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (sent < n) begin
        in_valid = rnd ? ($urandom % 4 != 0) : 1'b1;
        case ($urandom % 4)
          0: x = P_EXT + 65'($urandom % 8) - 65'd4;
          1: x = {P, 1'b0} + 65'($urandom % 8) - 65'd4;
          default: x = {1'($urandom % 2), $urandom, $urandom};
        endcase
        in_sum = x; in_tag = 8'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!rnd && sent < n) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready cyc=%0d got=%b exp=1", name, cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++; $display("FAIL %s_spurious got=%h exp=none", name, out_data);
        end else begin
          if (out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
            errors++;
            $display("FAIL %s_beat%0d got=%h/%h exp=%h/%h", name, got, out_data, out_tag, exp_d[0], exp_t[0]);
          end
          void'(exp_d.pop_front()); void'(exp_t.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_d.push_back(64'(in_sum % P_EXT));
        exp_t.push_back(in_tag);
        sent++;
      end
      step;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != n) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", name, got, n); end
    if (!rnd) begin
      checks++;
      if (cyc != n + 2) begin errors++; $display("FAIL %s_cycles got=%0d exp=%0d", name, cyc, n + 2); end
    end
  endtask

  task automatic test_back_to_back;
    run_stream(16, 1'b0, 200, "b2b");
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 65'd100; in_tag = 8'd1;
    step;
    in_sum = 65'd200; in_tag = 8'd2;
    step;
    in_sum = 65'd300; in_tag = 8'd3;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 8'd1 || out_data !== 64'd100)
        begin errors++; $display("FAIL stall_hold%0d got=%b/%h/%0d exp=1/01/100", i, out_valid, out_tag, out_data); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d got=%b exp=0", i, in_ready); end
      step;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    step;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd2 || out_data !== 64'd200)
      begin errors++; $display("FAIL stall_out2 got=%b/%h/%0d exp=1/02/200", out_valid, out_tag, out_data); end
    step;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd3 || out_data !== 64'd300)
      begin errors++; $display("FAIL stall_out3 got=%b/%h/%0d exp=1/03/300", out_valid, out_tag, out_data); end
    step;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_carry;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sum = 65'd7; in_carry = 1'b1; in_tag = 8'h55;
    step;
    in_valid = 1'b0; in_carry = 1'b0;
    checks++;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL carry_set got=%b exp=1", ovf_err); end
    step;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'd7 || out_tag !== 8'h55)
      begin errors++; $display("FAIL carry_data got=%b/%0d/%h exp=1/7/55", out_valid, out_data, out_tag); end
    step;
    checks++;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL carry_sticky got=%b exp=1", ovf_err); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL carry_clear got=%b exp=0", ovf_err); end
    clr_err = 1'b1; in_valid = 1'b1; in_carry = 1'b1; in_sum = 65'd3; in_tag = 8'h66;
    step;
    clr_err = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
    checks++;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL carry_set_wins got=%b exp=1", ovf_err); end
    step;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'd3) begin errors++; $display("FAIL carry_data2 got=%b/%0d exp=1/3", out_valid, out_data); end
    step;
  endtask

  task automatic test_rst_flight;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 65'h1234; in_tag = 8'hA1;
    step;
    in_sum = 65'h5678; in_tag = 8'hB2;
    step;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_filled got=%b exp=1", out_valid); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_tag !== 8'd0 || ovf_err !== 1'b0)
      begin errors++; $display("FAIL flight_rst got=%b/%h/%h/%b exp=0/0/0/0", out_valid, out_data, out_tag, ovf_err); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_ghost%0d got=%b/%h exp=0", i, out_valid, out_tag); end
    end
    in_valid = 1'b1; in_sum = P_EXT + 65'd9; in_tag = 8'hC3;
    step;
    in_valid = 1'b0;
    step;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'd9 || out_tag !== 8'hC3)
      begin errors++; $display("FAIL flight_next got=%b/%0d/%h exp=1/9/c3", out_valid, out_data, out_tag); end
    step;
  endtask

  task automatic test_random;
    run_stream(1000, 1'b1, 20000, "rand");
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_carry;
    test_rst_flight;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_reduce65_pipe.md
Name: mod_reduce65_pipe

Overview:
- Pipelined modular-reduction stage directly downstream of the 65-bit carry-lookahead adder in the radix-16 butterfly datapath.
- Consumes the adder's 65-bit sum and carry-out, and returns the value reduced modulo the NTT prime P as a 64-bit result.
- Two-stage conditional-subtract pipeline with valid/ready flow control and a sideband tag. A sticky error flag records adder carry-out overflow.

Parameters:
- DATA_WIDTH, 64, width of reduced result; input sum is DATA_WIDTH+1 bits.
- MODULUS, 64'hFFFFFFFF00000001, prime P; must satisfy 2^(DATA_WIDTH-1) < P < 2^DATA_WIDTH.
- TAG_W, 8, width of sideband tag carried alongside each beat.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  stage can accept input this cycle.
- in_sum  input  DATA_WIDTH+1  adder sum, value x.
- in_carry  input  1  adder carry-out; must be 0 for legal operands.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  DATA_WIDTH  x mod P (see Behaviour).
- out_tag  output  TAG_W  tag of the beat on out_data.
- ovf_err  output  1  sticky: an accepted beat had in_carry=1.
- clr_err  input  1  clears ovf_err.

Behaviour:
- Handshake:
  - Input transfers when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - out_data, out_tag and out_valid hold stable while out_valid=1 and out_ready=0.
- Pipeline: S1 register (valid v1, r1, tag1) and S2 register (valid v2, r2, tag2). out_valid=v2, out_data=r2, out_tag=tag2.
- Enables: en2 = !v2 | out_ready; en1 = !v1 | en2; in_ready = en1. These are combinational from out_ready; no combinational path from in_valid to in_ready.
- S1 load, when en1:
  - v1 <= in_valid & in_ready.
  - r1 <= (x >= 2P) ? x-2P : x, a DATA_WIDTH+1 bit value < 2P.
  - tag1 <= in_tag.
- S2 load, when en2:
  - v2 <= v1.
  - r2 <= (r1 >= P) ? r1-P : r1, truncated to DATA_WIDTH.
  - tag2 <= tag1.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle when out_ready=1.
- Correctness: out_data = x mod P for every x in [0, 2^(DATA_WIDTH+1)-1]. Since 2^(DATA_WIDTH+1) < 3P, two conditional subtracts suffice.
- Comparisons are unsigned and full width. 2P is formed at DATA_WIDTH+1 bits without overflow.
- in_carry:
  - in_carry is ignored for data, i.e. the value is treated as in_sum only.
  - If in_carry=1 on an accepted beat, ovf_err <= 1 the next cycle.
  - clr_err=1 clears ovf_err. If a clear and a new overflow beat coincide in the same cycle, set wins.
- Reset (rst=1 at an edge):
  - v1=v2=0, out_valid=0, ovf_err=0, r1=r2=0, tag1=tag2=0, out_data=0, out_tag=0.
  - Beats in flight when rst is asserted mid-operation are discarded and never presented.
  - in_ready=1 while rst=1, but no beat is captured during reset.
- Stall: when out_ready=0 with both stages full, in_ready=0. No beat is lost or duplicated.
- Bubble: when v2=0, S2 accepts S1 regardless of out_ready.

Test Plan:
- Reset, then single beats, each returned 2 cycles later with its tag:
  - x=5 -> 5.
  - x=P=0xFFFFFFFF00000001 -> 0.
  - x=2P-1=0x1_FFFFFFFE_00000001 -> 0xFFFFFFFF00000000.
  - x=2P=0x1_FFFFFFFE_00000002 -> 0.
  - x=2^65-1 -> 0x1_FFFFFFFD.
- Back-to-back stream of 16 random x with out_ready=1 -> one result per cycle, in order, each equal to x mod P, tags matching.
- Fill pipe with tags 1,2,3, hold out_ready=0 -> out_valid=1 with tag1 held stable, in_ready=0 once S1 and S2 are full. Release out_ready -> outputs 1,2,3 in order, no duplicates.
- Beat with in_carry=1 and x=7 -> output 7, ovf_err=1 the next cycle and held.
  - Assert clr_err alone -> ovf_err=0.
  - Assert clr_err together with a new carry beat -> ovf_err remains 1.
- Two beats in flight, assert rst for 1 cycle -> out_valid=0 and out_data=0 after the edge; neither beat ever appears; the next accepted beat x=P+9 -> 9 after 2 cycles.
- Random out_ready toggling (50%) with 1000 random x compared against a reference model -> no mismatches, no drops, no reordering.
